// File: rtl/i2c_master.sv
// Single-byte I2C master: START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP.
// Each SCL bit is four quarter periods of CLK_DIV clocks; the slave may stretch SCL in q2/q3.
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       rw_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o,
    output logic [7:0] data_o,
    input  logic       scl_i,
    output logic       scl_oe_o,
    input  logic       sda_i,
    output logic       sda_oe_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_ADDR,
        S_DATA,
        S_ACK_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] LP_CNT_LAST = 16'(CLK_DIV - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_cnt;
    logic [1:0]  r_quarter;
    logic [2:0]  r_bit;
    logic        r_rw;
    logic [6:0]  r_addr;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic [7:0]  r_data;
    logic        r_sda_smp;
    logic        r_done;
    logic        r_nack;

    logic        w_active;
    logic        w_stall;
    logic        w_tick;
    logic        w_bit_end;
    logic        w_smp_tick;
    logic        w_accept;
    logic [7:0]  w_addr_byte;

    // The quarter counter freezes while a slave holds SCL low after we released it.
    assign w_active    = (r_state != S_IDLE);
    assign w_stall     = r_quarter[1] && !scl_i;
    assign w_tick      = w_active && !w_stall && (r_cnt == LP_CNT_LAST);
    assign w_bit_end   = w_tick && (r_quarter == 2'd3);
    assign w_smp_tick  = w_tick && (r_quarter == 2'd2);
    assign w_accept    = (r_state == S_IDLE) && start_i;
    assign w_addr_byte = {r_addr, r_rw};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (start_i) w_next_state = S_START;
            S_START:    if (w_bit_end) w_next_state = S_ADDR;
            S_ADDR:     if (w_bit_end && (r_bit == 3'd0)) w_next_state = S_ACK_ADDR;
            S_ACK_ADDR: if (w_bit_end) w_next_state = r_sda_smp ? S_STOP : S_DATA;
            S_DATA:     if (w_bit_end && (r_bit == 3'd0)) w_next_state = S_ACK_DATA;
            S_ACK_DATA: if (w_bit_end) w_next_state = S_STOP;
            S_STOP:     if (w_bit_end) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= 16'd0;
            r_quarter <= 2'd0;
            r_bit     <= 3'd7;
            r_rw      <= 1'b0;
            r_addr    <= 7'd0;
            r_tx      <= 8'd0;
            r_rx      <= 8'd0;
            r_data    <= 8'd0;
            r_sda_smp <= 1'b0;
            r_done    <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_rw   <= rw_i;
                r_addr <= addr_i;
                r_tx   <= data_i;
                r_nack <= 1'b0;
                r_bit  <= 3'd7;
            end
            if (!w_active) begin
                r_cnt     <= 16'd0;
                r_quarter <= 2'd0;
            end else if (w_tick) begin
                r_cnt     <= 16'd0;
                r_quarter <= r_quarter + 2'd1;
            end else if (!w_stall) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_smp_tick) begin
                r_sda_smp <= sda_i;
                if (r_state == S_DATA) begin
                    r_rx <= {r_rx[6:0], sda_i};
                end
            end
            // ACK decisions use the level sampled at the end of q2 of the same bit.
            if (w_bit_end) begin
                case (r_state)
                    S_ADDR, S_DATA: r_bit <= r_bit - 3'd1;
                    S_ACK_ADDR: if (r_sda_smp) r_nack <= 1'b1;
                    S_ACK_DATA: begin
                        if (r_rw) begin
                            r_data <= r_rx;
                        end else if (r_sda_smp) begin
                            r_nack <= 1'b1;
                        end
                    end
                    S_STOP: r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        scl_oe_o = 1'b0;
        sda_oe_o = 1'b0;
        case (r_state)
            S_START: sda_oe_o = r_quarter[1];
            S_ADDR: begin
                scl_oe_o = !r_quarter[1];
                sda_oe_o = !w_addr_byte[r_bit];
            end
            S_ACK_ADDR, S_ACK_DATA: scl_oe_o = !r_quarter[1];
            S_DATA: begin
                scl_oe_o = !r_quarter[1];
                sda_oe_o = !r_rw && !r_tx[r_bit];
            end
            S_STOP: begin
                scl_oe_o = !r_quarter[1];
                sda_oe_o = (r_quarter != 2'd3);
            end
            default: ;
        endcase
    end

    assign busy_o = w_active;
    assign done_o = r_done;
    assign nack_o = r_nack;
    assign data_o = r_data;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: open-drain bus with pull-ups, a behavioural slave that can
// ACK/NACK and stretch SCL, a directed vector table and randomized transactions.
module tb_i2c_master;

    localparam int CLK_DIV  = 4;
    localparam int MAX_WAIT = 2000;

    typedef struct {
        string      name;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic       ackAddr;
        logic       ackData;
        logic [7:0] rdByte;
        int         stretchBit;
        int         stretchLen;
        logic [7:0] expWireAddr;
        logic [7:0] expWireData;
        logic       expNack;
        int         expCycles;
        logic [7:0] expDataO;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy;
    logic       done;
    logic       nack;
    logic [7:0] dataOut;
    logic       sclOe;
    logic       sdaOe;
    logic       slvSda = 1'b0;
    logic       stretch = 1'b0;
    logic       sclLine;
    logic       sdaLine;

    int         testsRun = 0;
    int         testsFailed = 0;

    logic       cfgRw = 1'b0;
    logic       cfgAckAddr = 1'b1;
    logic       cfgAckData = 1'b1;
    logic [7:0] cfgRdByte = 8'd0;
    int         cfgStretchBit = 0;
    int         cfgStretchLen = 0;

    int         bitIdx = 0;
    int         stopCount = 0;
    logic       prevScl = 1'b1;
    logic       prevSda = 1'b1;
    logic [7:0] obsAddr = 8'd0;
    logic [7:0] obsData = 8'd0;
    logic       obsAck2 = 1'b0;

    assign sclLine = ~sclOe & ~stretch;
    assign sdaLine = ~sdaOe & ~slvSda;

    always #5 clk = ~clk;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i    (clk),
        .rst_ni   (rstN),
        .start_i  (start),
        .rw_i     (rw),
        .addr_i   (addr),
        .data_i   (wdata),
        .busy_o   (busy),
        .done_o   (done),
        .nack_o   (nack),
        .data_o   (dataOut),
        .scl_i    (sclLine),
        .scl_oe_o (sclOe),
        .sda_i    (sdaLine),
        .sda_oe_o (sdaOe)
    );

    // Bit k is counted from the k-th SCL falling edge after START: 1..8 address, 9 ACK, 10..17 data, 18 ACK.
    function automatic logic slaveDrive(int k);
        if (k == 9) return cfgAckAddr;
        if (k >= 10 && k <= 17 && cfgAckAddr && cfgRw) return ~cfgRdByte[17 - k];
        if (k == 18 && cfgAckAddr && !cfgRw) return cfgAckData;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rstN) begin
            bitIdx  = 0;
            slvSda  = 1'b0;
            prevScl = 1'b1;
            prevSda = 1'b1;
        end else begin
            if (prevScl && sclLine && prevSda && !sdaLine) begin
                bitIdx  = 0;
                obsAddr = 8'd0;
                obsData = 8'd0;
                obsAck2 = 1'b0;
            end
            if (prevScl && sclLine && !prevSda && sdaLine) stopCount++;
            if (prevScl && !sclLine) begin
                bitIdx++;
                slvSda = slaveDrive(bitIdx);
            end
            if (!prevScl && sclLine) begin
                if (bitIdx >= 1 && bitIdx <= 8) obsAddr[8 - bitIdx] = sdaLine;
                else if (bitIdx >= 10 && bitIdx <= 17) obsData[17 - bitIdx] = sdaLine;
                else if (bitIdx == 18) obsAck2 = sdaLine;
            end
            prevScl = sclLine;
            prevSda = sdaLine;
        end
    end

    always @(negedge sclOe) begin
        if (rstN && cfgStretchLen > 0 && bitIdx == cfgStretchBit) begin
            stretch = 1'b1;
            repeat (cfgStretchLen) @(posedge clk);
            #1 stretch = 1'b0;
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkVec(string n, logic r, logic [6:0] a, logic [7:0] d, logic aa,
                                   logic ad, logic [7:0] rb, int sb, int sl, logic [7:0] ewa,
                                   logic [7:0] ewd, logic en, int ec, logic [7:0] edo);
        vec_t v;
        v.name = n; v.rw = r; v.addr = a; v.wdata = d; v.ackAddr = aa; v.ackData = ad;
        v.rdByte = rb; v.stretchBit = sb; v.stretchLen = sl; v.expWireAddr = ewa;
        v.expWireData = ewd; v.expNack = en; v.expCycles = ec; v.expDataO = edo;
        return v;
    endfunction

    // Transaction-level reference: quarters per phase, wire bytes and status from the protocol rules.
    function automatic vec_t refModel(vec_t v, logic [7:0] prevDataO);
        int quarters;
        quarters      = v.ackAddr ? (4 + 8 * 4 + 4 + 8 * 4 + 4 + 4) : (4 + 8 * 4 + 4 + 4);
        v.expWireAddr = {v.addr, v.rw};
        v.expWireData = v.rw ? v.rdByte : v.wdata;
        v.expNack     = !v.ackAddr || (!v.rw && !v.ackData);
        v.expCycles   = quarters * CLK_DIV + v.stretchLen;
        v.expDataO    = (v.rw && v.ackAddr) ? v.rdByte : prevDataO;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, output int cycles, output int stopsBefore);
        cfgRw         = v.rw;
        cfgAckAddr    = v.ackAddr;
        cfgAckData    = v.ackData;
        cfgRdByte     = v.rdByte;
        cfgStretchBit = v.stretchBit;
        cfgStretchLen = v.stretchLen;
        stopsBefore   = stopCount;
        @(negedge clk);
        rw    = v.rw;
        addr  = v.addr;
        wdata = v.wdata;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkValue({v.name, " busy after accept"}, 32'(busy), 32'd1);
        rw    = ~v.rw;
        addr  = ~v.addr;
        wdata = ~v.wdata;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == 40);
        end while (!done && cycles < MAX_WAIT);
        start = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v, input int cycles, input int stopsBefore);
        checkValue({v.name, " latency"}, 32'(cycles), 32'(v.expCycles));
        checkValue({v.name, " done"}, 32'(done), 32'd1);
        checkValue({v.name, " busy at done"}, 32'(busy), 32'd0);
        checkValue({v.name, " nack"}, 32'(nack), 32'(v.expNack));
        checkValue({v.name, " data_o"}, 32'(dataOut), 32'(v.expDataO));
        checkValue({v.name, " wire addr"}, 32'(obsAddr), 32'(v.expWireAddr));
        if (v.ackAddr) checkValue({v.name, " wire data"}, 32'(obsData), 32'(v.expWireData));
        if (v.ackAddr && v.rw) checkValue({v.name, " master nack"}, 32'(obsAck2), 32'd1);
        checkValue({v.name, " scl edges"}, 32'(bitIdx), v.ackAddr ? 32'd19 : 32'd10);
        checkValue({v.name, " stop seen"}, 32'(stopCount), 32'(stopsBefore + 1));
        checkValue({v.name, " lines idle"}, {30'd0, sclOe, sdaOe}, 32'd0);
        @(posedge clk);
        #1;
        checkValue({v.name, " done pulse width"}, 32'(done), 32'd0);
        checkValue({v.name, " no re-accept"}, 32'(busy), 32'd0);
        checkValue({v.name, " nack hold"}, 32'(nack), 32'(v.expNack));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs[7];
        vec_t       v;
        int         cycles;
        int         stops;
        int         w;
        logic [7:0] expDataO;

        vecs[0] = mkVec("wr5A",       0, 7'h5A, 8'hC3, 1, 1, 8'h00,  0,  0, 8'hB4, 8'hC3, 0, 320, 8'h00);
        vecs[1] = mkVec("rd21",       1, 7'h21, 8'h00, 1, 1, 8'hA5,  0,  0, 8'h43, 8'hA5, 0, 320, 8'hA5);
        vecs[2] = mkVec("addrNack",   0, 7'h33, 8'h55, 0, 1, 8'h00,  0,  0, 8'h66, 8'h00, 1, 176, 8'hA5);
        vecs[3] = mkVec("stretch50",  0, 7'h12, 8'h96, 1, 1, 8'h00, 14, 50, 8'h24, 8'h96, 0, 370, 8'hA5);
        vecs[4] = mkVec("dataNack",   0, 7'h7F, 8'h00, 1, 0, 8'h00,  0,  0, 8'hFE, 8'h00, 1, 320, 8'hA5);
        vecs[5] = mkVec("rdStretch",  1, 7'h00, 8'h00, 1, 1, 8'hFF, 16, 20, 8'h01, 8'hFF, 0, 340, 8'hFF);
        vecs[6] = mkVec("rdAddrNack", 1, 7'h40, 8'h00, 0, 1, 8'h3C,  0,  0, 8'h81, 8'h00, 1, 176, 8'hFF);

        #1;
        checkValue("reset busy", 32'(busy), 32'd0);
        checkValue("reset done", 32'(done), 32'd0);
        checkValue("reset nack", 32'(nack), 32'd0);
        checkValue("reset data_o", 32'(dataOut), 32'd0);
        checkValue("reset oe", {30'd0, sclOe, sdaOe}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], cycles, stops);
            checkOutput(vecs[i], cycles, stops);
        end
        expDataO = vecs[6].expDataO;

        // start_i held high across done_o must start the next transfer right away.
        cfgRw = 1'b0; cfgAckAddr = 1'b1; cfgAckData = 1'b1; cfgStretchLen = 0;
        @(negedge clk);
        rw = 1'b0; addr = 7'h3C; wdata = 8'h81; start = 1'b1;
        @(posedge clk);
        #1;
        cycles = 0;
        do begin @(posedge clk); #1; cycles++; end while (!done && cycles < MAX_WAIT);
        checkValue("held first latency", 32'(cycles), 32'd320);
        checkValue("held lines at done", {30'd0, sclOe, sdaOe}, 32'd0);
        checkValue("held busy at done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkValue("held re-accept", 32'(busy), 32'd1);
        cycles = 0;
        do begin @(posedge clk); #1; cycles++; end while (!done && cycles < MAX_WAIT);
        checkValue("held second latency", 32'(cycles), 32'd320);
        checkValue("held second nack", 32'(nack), 32'd0);
        checkValue("held second wire data", 32'(obsData), 32'h81);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            v.name       = $sformatf("rand%0d", i);
            v.rw         = 1'($urandom_range(0, 1));
            v.addr       = 7'($urandom);
            v.wdata      = 8'($urandom);
            v.ackAddr    = ($urandom_range(0, 3) != 0);
            v.ackData    = ($urandom_range(0, 3) != 0);
            v.rdByte     = 8'($urandom);
            v.stretchBit = 0;
            v.stretchLen = 0;
            if ($urandom_range(0, 2) == 0) begin
                v.stretchLen = int'($urandom_range(1, 30));
                v.stretchBit = int'($urandom_range(1, v.ackAddr ? 18 : 9));
            end
            v        = refModel(v, expDataO);
            expDataO = v.expDataO;
            applyStimulus(v, cycles, stops);
            checkOutput(v, cycles, stops);
        end

        // Reset in the middle of the data byte abandons the transfer without a STOP.
        cfgRw = 1'b0; cfgAckAddr = 1'b1; cfgAckData = 1'b1; cfgStretchLen = 0;
        @(negedge clk);
        rw = 1'b0; addr = 7'h2B; wdata = 8'hF0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        w = 0;
        while (bitIdx != 12 && w < MAX_WAIT) begin @(posedge clk); #1; w++; end
        checkValue("reached data phase", 32'(w < MAX_WAIT), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkValue("mid reset oe", {30'd0, sclOe, sdaOe}, 32'd0);
        checkValue("mid reset busy", 32'(busy), 32'd0);
        checkValue("mid reset done", 32'(done), 32'd0);
        checkValue("mid reset data_o", 32'(dataOut), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        expDataO = 8'h00;
        v = mkVec("postReset", 0, 7'h2B, 8'h0F, 1, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
        v = refModel(v, expDataO);
        applyStimulus(v, cycles, stops);
        checkOutput(v, cycles, stops);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
